// File: rtl/debounce_pkg.sv
// debounce_pkg: default parameters and counter sizing shared by the debounce blocks
package debounce_pkg;
  localparam int DEF_N_CH = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 500;
  localparam int DEF_HOLD_CYCLES = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 10_000_000;
  // Bits needed to hold any value 0..n
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one channel -- synchroniser, debounce counter, level, edge pulses, optional long-press (DEBOUNCE_LONG_PRESS_EN)
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  logic [1:0] sync_ff;
  logic [CW-1:0] cnt;
  logic sync, diff, flip;
  assign sync = sync_ff[1];
  assign diff = sync != level;
  assign flip = diff && cnt == CW'(DEBOUNCE_CYCLES - 1);
  // Synchronise, count disagreeing samples, accept the new level after a full run
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= '0;
      cnt <= '0;
      level <= 1'b0;
      press <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], in};
      cnt <= diff && !flip ? cnt + 1'b1 : '0;
      level <= flip ? sync : level;
      press <= flip && sync;
      release_pulse <= flip && !sync;
    end
  end
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int HW = cnt_width(HOLD_CYCLES);
  logic [HW-1:0] hold;
  logic hit;
  assign hit = level && hold == HW'(HOLD_CYCLES - 1);
  // Count held-high cycles; on each hit rewind so the next hit lands REPEAT_CYCLES later
  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
      long_press <= 1'b0;
    end else begin
      hold <= !level ? '0 : hit ? HW'(HOLD_CYCLES - REPEAT_CYCLES) : hold + 1'b1;
      long_press <= hit;
    end
  end
`else
  // Hold timing is irrelevant without the long-press logic; the output is constant low
  assign long_press = (REPEAT_CYCLES > HOLD_CYCLES) && 1'b0;
`endif
endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: N_CH independent debounced inputs with press/release/long-press pulses (DEBOUNCE_LONG_PRESS_EN enables long_press)
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_press
);
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_chan (
      .clk(clk),
      .rst(rst),
      .in(in[g]),
      .level(level[g]),
      .press(press[g]),
      .release_pulse(release_pulse[g]),
      .long_press(long_press[g])
    );
  end
endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 Parameter N_CH, default 4, number of independent debounce channels (>=1).
REQ-002 Parameter DEBOUNCE_CYCLES, default 500, consecutive disagreeing samples needed to accept a new level (>=1).
REQ-003 Parameter HOLD_CYCLES, default 50_000_000, cycles of held-high level before the first long_press pulse (>=1).
REQ-004 Parameter REPEAT_CYCLES, default 10_000_000, cycles between auto-repeat long_press pulses (>=1, <=HOLD_CYCLES).
REQ-005 clk  input  1  sole clock, all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in  input  N_CH  raw asynchronous button/switch inputs.
REQ-008 level  output  N_CH  debounced level per channel.
REQ-009 press  output  N_CH  one-cycle pulse on debounced 0->1.
REQ-010 release  output  N_CH  one-cycle pulse on debounced 1->0.
REQ-011 long_press  output  N_CH  one-cycle pulse on hold threshold and each auto-repeat.

Function
REQ-012 Each in bit SHALL pass through a 2-flop synchroniser; the second flop output (sync) is the only value the debouncer samples.
REQ-013 Per channel, a counter SHALL increment each cycle sync != level and clear to 0 on any cycle sync == level.
REQ-014 On the edge where sync != level and the counter equals DEBOUNCE_CYCLES-1, level SHALL take sync and the counter SHALL clear.
REQ-015 Total latency from a stable change on in to level change SHALL be exactly 2 + DEBOUNCE_CYCLES edges; any glitch shorter than DEBOUNCE_CYCLES samples SHALL leave level unchanged.
REQ-016 press/release SHALL be high for exactly the one cycle in which the new level first appears, never both in one cycle.
REQ-017 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) bits; counter SHALL never wrap.
REQ-018 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-019 While rst is high: sync flops, level, press, release, long_press and all counters SHALL be 0 on the next edge.
REQ-020 Reset asserted mid-count or mid-hold SHALL discard progress; an input held high through reset SHALL produce press only after a full 2 + DEBOUNCE_CYCLES edges after rst deasserts.

Configuration
REQ-021 Macro DEBOUNCE_LONG_PRESS_EN defined: per-channel hold counter counts cycles with level==1; long_press pulses when it reaches HOLD_CYCLES, then every REPEAT_CYCLES while level stays 1; counter clears when level is 0.
REQ-022 Macro undefined: hold counters absent from RTL, long_press tied to 0, all other behaviour identical.

Structure
REQ-023 Package debounce_pkg SHALL hold default parameter constants and the counter-width function.
REQ-024 Sub-module debounce_chan SHALL implement one channel (sync, counter, level, pulses, optional hold logic); debounce_multi SHALL instantiate N_CH of them in a generate loop.

Verification (bench: N_CH=4, DEBOUNCE_CYCLES=8, HOLD_CYCLES=20, REPEAT_CYCLES=5)
REQ-025 in[0] 0->1 held -> level[0]=1 and press[0]=1 for one cycle exactly 10 edges later; other channels stay 0.
REQ-026 in[1] high for 7 cycles then low -> level[1], press[1], release[1] stay 0 throughout.
REQ-027 in[2] bounce 1,0,1,0 every 3 cycles then high -> press[2] 10 edges after final rise, single pulse only.
REQ-028 in[3] held high 60 cycles after level rise (macro on) -> long_press[3] pulses at hold counts 20, 25, 30, ...; macro off -> long_press stays 0.
REQ-029 in=4'b1111 simultaneously, later 4'b0000 -> four press pulses same cycle, then four release pulses same cycle.
REQ-030 rst pulsed at counter value 5 with in[0] high -> all outputs 0; press[0] reappears 10 edges after rst deasserts.
